fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/all_pkgs.sv | 20 ++
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/all_pkgs.sv
// Shared types and constants for the instruction-fetch front end.
package all_pkgs;

    localparam int              WIDTH    = 32;
    localparam int              FQ_DEPTH = 2;
    localparam logic [WIDTH-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small in-order fetch queue: pc/instruction pairs with flush and valid/ready drain.
module fetch_queue
    import all_pkgs::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  fq_entry_t push_data,
    output logic      in_ready,
    output logic      one_left,
    output logic      out_valid,
    input  logic      out_ready,
    output fq_entry_t out_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fq_entry_t     mem_q [DEPTH];
    logic          pop;
    logic          push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = (count_q != CW'(DEPTH)) || pop;
    assign one_left  = (count_q == CW'(DEPTH - 1));
    assign push_ok   = push && in_ready;
    // Gating with out_valid makes the head read zero whenever empty, including in reset.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: boot/fetch/full/halt FSM, program counter and sticky misalignment flag.
module fetch_ctrl
    import all_pkgs::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               FQ_DEPTH = all_pkgs::FQ_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic             misalign_err
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_q, err_d;
    logic             push, flush, in_ready, one_left, deq;
    fq_entry_t        head;

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ('{pc: pc_q, instr: imem_instr}),
        .in_ready  (in_ready),
        .one_left  (one_left),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign deq          = out_valid && out_ready;
    assign imem_addr    = pc_q;
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign misalign_err = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH, FULL: begin
                if (redirect_valid) begin
                    // Redirect wins over fetch and drain; a misaligned target parks the front end.
                    flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = FETCH;
                    end
                end else if (state_q == FETCH) begin
                    if (in_ready) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_STEP;
                        if (!deq && one_left) state_d = FULL;
                    end else begin
                        state_d = FULL;
                    end
                end else if (deq) begin
                    state_d = FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; instruction memory returns word index (addr >> 2).
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    assign imem_instr = {2'b00, imem_addr[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic reset_dut(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", out_instr); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", misalign_err); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        reset_dut(1'b1);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            n_checks++; if (out_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 32'(4 * i)); end
            n_checks++; if (out_instr !== 32'(i)) begin n_fail++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, 32'(i)); end
        end
    endtask

    task automatic test_backpressure();
        reset_dut(1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head[%0d] got=%h/%b exp=0/1", i, out_pc, out_valid); end
            n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_pc[%0d] got=%h exp=8", i, imem_addr); end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_drain[%0d] got=%h/%b exp=%h/1", k, out_pc, out_valid, 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect();
        reset_dut(1'b0);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (out_pc !== 32'h4 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL redir_pre got=%h/%h exp=4/c", out_pc, imem_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        out_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", out_valid); end
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h40) begin n_fail++; $display("FAIL redir_t0 got=%h/%h exp=100/40", out_pc, out_instr); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_instr !== 32'h41) begin n_fail++; $display("FAIL redir_t1 got=%h/%h exp=104/41", out_pc, out_instr); end
    endtask

    task automatic test_misalign();
        reset_dut(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%b exp=1", misalign_err); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid got=%b exp=0", out_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0 || misalign_err !== 1'b1) begin n_fail++; $display("FAIL halt[%0d] got=%b/%b exp=0/1", i, out_valid, misalign_err); end
            n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL halt_pc[%0d] got=%h exp=8", i, imem_addr); end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL mis_restart got=%h/%b exp=0/1", out_pc, out_valid); end
    endtask

    task automatic test_wrap();
        reset_dut(1'b1);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_flush got=%b exp=0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_pc !== 32'hFFFF_FFF8 || out_instr !== 32'h3FFF_FFFE) begin n_fail++; $display("FAIL wrap0 got=%h/%h exp=fffffff8/3ffffffe", out_pc, out_instr); end
        @(negedge clk);
        n_checks++; if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap1 got=%h/%h exp=fffffffc/3fffffff", out_pc, out_instr); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL wrap2 got=%h/%h exp=0/0", out_pc, out_instr); end
    endtask

    task automatic test_async_reset();
        reset_dut(1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL ar_full got=%b/%h exp=1/8", out_valid, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL ar_now got=%b/%h/%h exp=0/0/0", out_valid, out_pc, out_instr); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_addr got=%h exp=0", imem_addr); end
        @(negedge clk);
        rst_n          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_boot got=%b exp=0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL ar_first got=%h/%b exp=0/1", out_pc, out_valid); end
        @(negedge clk);
        n_checks++; if (out_pc !== 32'h4) begin n_fail++; $display("FAIL ar_second got=%h exp=4", out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
